// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: IF-stage controller for the 16-bit bit-cell PC register.
// It drives the register's write port (D / WriteReg / ReadEnable1 / ReadEnable2),
// reads the stored PC back from Bitline1 and chooses the next fetch address:
// sequential step, branch redirect, stall with a buffered redirect, or HLT.
//
// fetch_valid is a one-way qualifier with no back-pressure. When it is 1, the
// instruction at pc_rd and pc_plus_step are valid for the IF/ID latch in this
// cycle. When it is 0, IF/ID must treat the slot as a bubble. Stalls are
// signalled by the hazard unit through the stall input, not through a ready.
module pc_fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2,
  parameter logic [3:0]  HALT_OPC = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] instr,
  input  logic        dbg_rd,
  input  logic [15:0] pc_rd,
  output logic [15:0] pc_d,
  output logic        pc_we,
  output logic        pc_re1,
  output logic        pc_re2,
  output logic [15:0] pc_plus_step,
  output logic        fetch_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] pend_addr_q, pend_addr_d;

  // Sequential address. It wraps modulo 2^16 and has no carry-out.
  assign pc_plus_step = pc_rd + PC_STEP;

  // State and pending-redirect registers. Reset discards any buffered redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  // Next-state logic and register-port outputs.
  // pc_rd reaches only pc_d and never the state or pending registers.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pc_d         = RESET_PC;
    pc_we        = 1'b0;
    pc_re1       = 1'b0;
    pc_re2       = 1'b0;
    fetch_valid  = 1'b0;
    halted       = 1'b0;
    if (!rst) begin
      pc_re1 = 1'b1;
      pc_re2 = dbg_rd;
      unique case (state_q)
        S_INIT: begin
          pc_we   = 1'b1;
          pc_d    = RESET_PC;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (stall) begin
            if (branch_taken) begin
              pend_addr_d  = branch_target;
              pend_valid_d = 1'b1;
            end
            state_d = S_HOLD;
          end else if (branch_taken) begin
            // The instruction fetched at pc_rd is on the wrong path, so it is flushed.
            pc_we = 1'b1;
            pc_d  = branch_target;
          end else if (instr[15:12] == HALT_OPC) begin
            // Rewrite the current PC so that fetch stays parked on the HLT.
            pc_we       = 1'b1;
            pc_d        = pc_rd;
            fetch_valid = 1'b1;
            state_d     = S_HALT;
          end else begin
            pc_we       = 1'b1;
            pc_d        = pc_plus_step;
            fetch_valid = 1'b1;
          end
        end
        S_HOLD: begin
          if (stall) begin
            // If several redirects arrive during a stall, the youngest one is kept.
            if (branch_taken) begin
              pend_addr_d  = branch_target;
              pend_valid_d = 1'b1;
            end
          end else begin
            pc_we        = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = S_RUN;
            if (branch_taken) begin
              pc_d = branch_target;
            end else if (pend_valid_q) begin
              pc_d = pend_addr_q;
            end else begin
              pc_d        = pc_plus_step;
              fetch_valid = 1'b1;
            end
          end
        end
        S_HALT: begin
          // An older taken branch proves the HLT was speculative, so fetch resumes.
          if (branch_taken) begin
            pc_we   = 1'b1;
            pc_d    = branch_target;
            state_d = S_RUN;
          end else begin
            halted = 1'b1;
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed testbench for pc_fetch_sequencer. It contains a behavioural model
// of the bit-cell PC register, so pc_rd follows pc_d one cycle after each write.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instr;
  logic        dbg_rd;
  logic [15:0] pc_rd;
  logic [15:0] pc_d;
  logic        pc_we;
  logic        pc_re1;
  logic        pc_re2;
  logic [15:0] pc_plus_step;
  logic        fetch_valid;
  logic        halted;

  int vectors     = 0;
  int miscompares = 0;

  // Clock generation.
  always #5 clk = ~clk;

  // Model of the PC register. It has no reset and powers up at an arbitrary value.
  logic [15:0] pc_reg = 16'h1234;
  always @(posedge clk) if (pc_we) pc_reg <= pc_d;
  assign pc_rd = pc_reg;

  pc_fetch_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr(instr), .dbg_rd(dbg_rd),
    .pc_rd(pc_rd), .pc_d(pc_d), .pc_we(pc_we), .pc_re1(pc_re1),
    .pc_re2(pc_re2), .pc_plus_step(pc_plus_step),
    .fetch_valid(fetch_valid), .halted(halted)
  );

  // Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    instr = 16'h0000; dbg_rd = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    vectors++; if (pc_we !== 1'b0) begin miscompares++; $display("FAIL rst_pc_we got %b exp 0", pc_we); end
    vectors++; if (pc_re1 !== 1'b0) begin miscompares++; $display("FAIL rst_pc_re1 got %b exp 0", pc_re1); end
    vectors++; if (pc_re2 !== 1'b0) begin miscompares++; $display("FAIL rst_pc_re2 got %b exp 0", pc_re2); end
    vectors++; if (fetch_valid !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL rst_flags got fv=%b h=%b exp 0 0", fetch_valid, halted); end
    vectors++; if (pc_d !== 16'h0000) begin miscompares++; $display("FAIL rst_pc_d got %h exp 0000", pc_d); end
    next_cycle();
    rst = 1'b0;
    settle();
    vectors++; if (pc_we !== 1'b1 || pc_d !== 16'h0000) begin miscompares++; $display("FAIL init_write got we=%b d=%h exp 1 0000", pc_we, pc_d); end
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL init_fv got %b exp 0", fetch_valid); end
    vectors++; if (pc_re1 !== 1'b1 || pc_re2 !== 1'b1) begin miscompares++; $display("FAIL init_re got %b%b exp 11", pc_re1, pc_re2); end
    dbg_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      settle();
      exp = 16'(2 * i);
      vectors++; if (pc_rd !== exp) begin miscompares++; $display("FAIL seq_pc_rd[%0d] got %h exp %h", i, pc_rd, exp); end
      vectors++; if (fetch_valid !== 1'b1 || pc_we !== 1'b1) begin miscompares++; $display("FAIL seq_fv_we[%0d] got %b%b exp 11", i, fetch_valid, pc_we); end
      vectors++; if (pc_d !== 16'(exp + 16'd2)) begin miscompares++; $display("FAIL seq_pc_d[%0d] got %h exp %h", i, pc_d, 16'(exp + 16'd2)); end
      vectors++; if (pc_re2 !== 1'b0) begin miscompares++; $display("FAIL seq_re2[%0d] got %b exp 0", i, pc_re2); end
    end
  endtask

  task automatic test_wrap();
    next_cycle();
    branch_taken = 1'b1; branch_target = 16'hFFFC;
    settle();
    vectors++; if (pc_we !== 1'b1 || pc_d !== 16'hFFFC || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_redirect got we=%b d=%h fv=%b exp 1 fffc 0", pc_we, pc_d, fetch_valid); end
    next_cycle();
    branch_taken = 1'b0;
    settle();
    vectors++; if (pc_rd !== 16'hFFFC || pc_d !== 16'hFFFE) begin miscompares++; $display("FAIL wrap_fffc got rd=%h d=%h exp fffc fffe", pc_rd, pc_d); end
    next_cycle();
    settle();
    vectors++; if (pc_plus_step !== 16'h0000 || pc_d !== 16'h0000) begin miscompares++; $display("FAIL wrap_fffe got ps=%h d=%h exp 0000 0000", pc_plus_step, pc_d); end
    next_cycle();
    settle();
    vectors++; if (pc_rd !== 16'h0000 || fetch_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_zero got rd=%h fv=%b exp 0000 1", pc_rd, fetch_valid); end
  endtask

  task automatic test_branch_during_stall();
    next_cycle();
    branch_taken = 1'b1; branch_target = 16'h0010;
    settle();
    next_cycle();
    branch_taken = 1'b0; stall = 1'b1;
    settle();
    vectors++; if (pc_rd !== 16'h0010 || pc_we !== 1'b0 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL stall1 got rd=%h we=%b fv=%b exp 0010 0 0", pc_rd, pc_we, fetch_valid); end
    next_cycle();
    branch_taken = 1'b1; branch_target = 16'h0100;
    settle();
    vectors++; if (pc_we !== 1'b0 || pc_rd !== 16'h0010) begin miscompares++; $display("FAIL stall2 got we=%b rd=%h exp 0 0010", pc_we, pc_rd); end
    next_cycle();
    branch_taken = 1'b0;
    settle();
    vectors++; if (pc_we !== 1'b0 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL stall3 got we=%b fv=%b exp 0 0", pc_we, fetch_valid); end
    next_cycle();
    stall = 1'b0;
    settle();
    vectors++; if (pc_we !== 1'b1 || pc_d !== 16'h0100 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release got we=%b d=%h fv=%b exp 1 0100 0", pc_we, pc_d, fetch_valid); end
    next_cycle();
    settle();
    vectors++; if (pc_rd !== 16'h0100 || pc_d !== 16'h0102 || fetch_valid !== 1'b1) begin miscompares++; $display("FAIL stall_after got rd=%h d=%h fv=%b exp 0100 0102 1", pc_rd, pc_d, fetch_valid); end
  endtask

  task automatic test_simultaneous();
    next_cycle();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0100;
    settle();
    vectors++; if (pc_we !== 1'b0) begin miscompares++; $display("FAIL simul_hold got we=%b exp 0", pc_we); end
    next_cycle();
    stall = 1'b0; branch_taken = 1'b1; branch_target = 16'h0200;
    settle();
    vectors++; if (pc_we !== 1'b1 || pc_d !== 16'h0200 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL simul_pick got we=%b d=%h fv=%b exp 1 0200 0", pc_we, pc_d, fetch_valid); end
    next_cycle();
    branch_taken = 1'b0;
    settle();
    vectors++; if (pc_rd !== 16'h0200 || pc_d !== 16'h0202) begin miscompares++; $display("FAIL simul_after got rd=%h d=%h exp 0200 0202", pc_rd, pc_d); end
    // A stall without a branch must release to the sequential address, which shows the pending redirect was cleared.
    next_cycle();
    stall = 1'b1;
    settle();
    next_cycle();
    stall = 1'b0;
    settle();
    vectors++; if (pc_d !== 16'h0204 || fetch_valid !== 1'b1 || pc_we !== 1'b1) begin miscompares++; $display("FAIL simul_pend_clear got d=%h fv=%b we=%b exp 0204 1 1", pc_d, fetch_valid, pc_we); end
  endtask

  task automatic test_halt();
    next_cycle();
    branch_taken = 1'b1; branch_target = 16'h0020;
    settle();
    next_cycle();
    branch_taken = 1'b0; instr = 16'hF000;
    settle();
    vectors++; if (pc_rd !== 16'h0020 || pc_d !== 16'h0020 || pc_we !== 1'b1 || fetch_valid !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("FAIL hlt_fetch got rd=%h d=%h we=%b fv=%b h=%b exp 0020 0020 1 1 0", pc_rd, pc_d, pc_we, fetch_valid, halted); end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      instr = 16'h0000;
      stall = (i == 2);
      settle();
      vectors++; if (halted !== 1'b1 || pc_we !== 1'b0 || fetch_valid !== 1'b0 || pc_rd !== 16'h0020) begin miscompares++; $display("FAIL hlt_hold[%0d] got h=%b we=%b fv=%b rd=%h exp 1 0 0 0020", i, halted, pc_we, fetch_valid, pc_rd); end
    end
    next_cycle();
    stall = 1'b0; branch_taken = 1'b1; branch_target = 16'h0040;
    settle();
    vectors++; if (halted !== 1'b0 || pc_we !== 1'b1 || pc_d !== 16'h0040) begin miscompares++; $display("FAIL hlt_flush got h=%b we=%b d=%h exp 0 1 0040", halted, pc_we, pc_d); end
    next_cycle();
    branch_taken = 1'b0;
    settle();
    vectors++; if (pc_rd !== 16'h0040 || pc_d !== 16'h0042 || fetch_valid !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("FAIL hlt_resume got rd=%h d=%h fv=%b h=%b exp 0040 0042 1 0", pc_rd, pc_d, fetch_valid, halted); end
  endtask

  task automatic test_async_reset();
    next_cycle();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0300;
    settle();
    next_cycle();
    branch_taken = 1'b0;
    settle();
    vectors++; if (pc_we !== 1'b0 || pc_re1 !== 1'b1) begin miscompares++; $display("FAIL arst_prehold got we=%b re1=%b exp 0 1", pc_we, pc_re1); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (pc_we !== 1'b0 || pc_re1 !== 1'b0) begin miscompares++; $display("FAIL arst_immediate got we=%b re1=%b exp 0 0", pc_we, pc_re1); end
    next_cycle();
    rst = 1'b0; stall = 1'b0;
    settle();
    vectors++; if (pc_we !== 1'b1 || pc_d !== 16'h0000) begin miscompares++; $display("FAIL arst_init got we=%b d=%h exp 1 0000", pc_we, pc_d); end
    next_cycle();
    settle();
    vectors++; if (pc_rd !== 16'h0000 || pc_d !== 16'h0002 || fetch_valid !== 1'b1) begin miscompares++; $display("FAIL arst_run got rd=%h d=%h fv=%b exp 0000 0002 1", pc_rd, pc_d, fetch_valid); end
    next_cycle();
    settle();
    vectors++; if (pc_rd !== 16'h0002) begin miscompares++; $display("FAIL arst_no_pend got rd=%h exp 0002", pc_rd); end
  endtask

  // Run the scenarios in order, then print the report.
  initial begin
    test_reset();
    test_wrap();
    test_branch_during_stall();
    test_simultaneous();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Drives the write side of the 16-bit bit-cell PC register: D, WriteReg, ReadEnable1 and ReadEnable2.
- Reads the stored PC back from Bitline1 and computes the next fetch address.
- Handles sequential increment, branch redirect, pipeline stall with a buffered redirect, and HLT detection.
- Sits in the IF stage, between the PC register, the instruction memory address port and the EX-stage branch resolution.

Parameters:
- RESET_PC, 16'h0000, address written into the PC register in the first cycle after reset.
- PC_STEP, 16'd2, sequential increment in bytes.
- HALT_OPC, 4'hF, opcode in instr[15:12] that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit freezes the PC this cycle.
- branch_taken  in  1  EX stage resolved a taken branch/jump; single-cycle pulse.
- branch_target  in  16  redirect address, valid with branch_taken.
- instr  in  16  instruction fetched at the current PC.
- dbg_rd  in  1  debug request for a second read of the PC.
- pc_rd  in  16  PC register Bitline1 readback.
- pc_d  out  16  PC register D.
- pc_we  out  1  PC register WriteReg.
- pc_re1  out  1  PC register ReadEnable1.
- pc_re2  out  1  PC register ReadEnable2.
- pc_plus_step  out  16  pc_rd + PC_STEP, for the IF/ID pipeline latch.
- fetch_valid  out  1  instruction at pc_rd is valid for IF/ID this cycle.
- halted  out  1  processor halted.

Behaviour:
- Output timing: all outputs are combinational from state, the pending register and the inputs. The PC register captures pc_d on the clk edge where pc_we=1, so the new PC is visible on pc_rd one cycle after the write.
- Reset (rst=1, any time, asynchronous):
  - State goes to INIT; pend_valid=0; pend_addr=0.
  - While rst=1: pc_we=0, pc_re1=0, pc_re2=0, fetch_valid=0, halted=0, pc_d=RESET_PC.
  - Reset mid-stall or mid-halt discards any pending redirect.
- pc_re1: 1 in every state while rst=0.
- pc_re2: equals dbg_rd while rst=0, else 0.
- pc_plus_step: (pc_rd + PC_STEP) mod 2^16; 16'hFFFE+2 gives 16'h0000. No carry-out or flag.
- State INIT:
  - pc_we=1, pc_d=RESET_PC, fetch_valid=0.
  - Goes to RUN after one cycle. Inputs are ignored.
- State RUN, priority top-down:
  1. stall=1: pc_we=0, fetch_valid=0. If branch_taken=1, latch pend_addr=branch_target and pend_valid=1. Go to HOLD.
  2. branch_taken=1: pc_we=1, pc_d=branch_target, fetch_valid=0 (the fetched instruction is flushed). Stay in RUN.
  3. instr[15:12]==HALT_OPC: pc_we=1, pc_d=pc_rd (PC holds at the HLT), fetch_valid=1. Go to HALT.
  4. Otherwise: pc_we=1, pc_d=pc_plus_step, fetch_valid=1. Stay in RUN.
- State HOLD:
  - stall=1: pc_we=0, fetch_valid=0. A new branch_taken overwrites pend_addr (youngest redirect wins). Stay in HOLD.
  - stall=0: pc_we=1; pend_valid=0 afterwards; go to RUN. fetch_valid=0 if a redirect is applied, else 1. pc_d is chosen in this order:
    - branch_taken=1 this cycle: branch_target.
    - else pend_valid=1: pend_addr.
    - else: pc_plus_step.
- State HALT:
  - halted=1, pc_we=0, fetch_valid=0.
  - branch_taken=1 (an older branch flushes a speculative HLT): pc_we=1, pc_d=branch_target, halted=0 in that same cycle, go to RUN.
  - stall is ignored in HALT. Only reset or branch_taken leaves HALT.
- branch_target is written unmodified; no alignment checking.
- No X may propagate from pc_rd into state; state and pending registers depend only on the listed control inputs.

Test Plan:
1. Reset and sequential run: assert rst, release. Expect INIT cycle pc_we=1, pc_d=0000. Then with NOP instrs, pc_rd reads 0000, 0002, 0004, 0006 on consecutive cycles with fetch_valid=1.
2. Wrap-around: redirect to FFFC, then sequential. Expect pc_d values FFFE then 0000; pc_plus_step=0000 when pc_rd=FFFE.
3. Branch during stall: in RUN at pc 0010, assert stall for 3 cycles with branch_taken and target 0100 in the second stall cycle, then drop stall. Expect pc_we=0 throughout the stall; pc_d=0100 with pc_we=1 when stall drops; pc_rd=0100 next cycle.
4. Simultaneous events: in HOLD with pend_addr=0100, drop stall and pulse branch_taken with target 0200 in the same cycle. Expect pc_d=0200 and pend_valid cleared.
5. Halt and flush: instr=F000 at pc 0020. Expect pc_d=0020, then halted=1 and pc_we=0 for 5 cycles. Then pulse branch_taken with target 0040: expect halted=0, pc_we=1, pc_d=0040 in that cycle, and RUN resumes.
6. Async reset mid-HOLD: with pend_valid=1 and pend_addr=0300, assert rst between clock edges. Expect pc_we and pc_re1 to drop immediately. After release, pc_rd=RESET_PC and the pending 0300 is never written.
